multichannel_sensor_fifo: RTL and testbench

MULTICHANNEL_SENSOR_FIFO -- requirements
Module: multichannel_sensor_fifo

---
 rtl/multichannel_sensor_fifo.sv | 197 +++++++++++++++++++
 tb/tb_multichannel_sensor_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_sensor_fifo.sv
`timescale 1ns/1ps
// multichannel_sensor_fifo
// Collects samples from NUM_CHANNELS sensor channels into one shared FIFO.
// Each channel has a one-entry holding register. A round-robin arbiter moves
// at most one held sample per cycle into the FIFO, tagged with its channel index.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   sensor_valid/_data    per-channel sample strobe and data (channel i at [i*DATA_WIDTH +: DATA_WIDTH])
//   sensor_ready          channel holding register is free
//   read_enable           pop the head entry
//   fifo_output/_channel  head entry data and source channel (first-word fall-through)
//   fifo_empty/_full, almost_full/_empty, fifo_count   occupancy status
//   overflow_flag, underflow_flag, clear_flags         sticky error flags and their clear
module multichannel_sensor_fifo #(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned FIFO_DEPTH         = 32,
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned ALMOST_FULL_LEVEL  = FIFO_DEPTH - 4,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 4,
    parameter int unsigned OVERWRITE_MODE     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS-1:0]              sensor_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   sensor_data,
    output logic [NUM_CHANNELS-1:0]              sensor_ready,
    input  logic                                 read_enable,
    output logic [DATA_WIDTH-1:0]                fifo_output,
    output logic [$clog2(NUM_CHANNELS)-1:0]      fifo_channel,
    output logic                                 fifo_empty,
    output logic                                 fifo_full,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
    output logic                                 overflow_flag,
    output logic                                 underflow_flag,
    input  logic                                 clear_flags
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(NUM_CHANNELS);
    localparam int unsigned CW1  = CW + 1;

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] AF_LVL   = CNTW'(ALMOST_FULL_LEVEL);
    localparam logic [CNTW-1:0] AE_LVL   = CNTW'(ALMOST_EMPTY_LEVEL);
    localparam logic [CW1-1:0]  NCH      = CW1'(NUM_CHANNELS);
    localparam logic [CW-1:0]   LAST_CH  = CW'(NUM_CHANNELS - 1);

    typedef struct packed {
        logic [CW-1:0]         ch;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [NUM_CHANNELS-1:0]                 hold_valid_q, hold_valid_d;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [CW-1:0]                           prio_q, prio_d;
    logic [CW-1:0]                           gnt_idx;
    logic                                    gnt_found;
    logic [CW1-1:0]                          cand;
    logic [AW-1:0]                           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                           rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]                         count_q, count_d;
    logic                                    ovf_q, ovf_d;
    logic                                    unf_q, unf_d;
    entry_t                                  mem_q [FIFO_DEPTH];
    entry_t                                  head;
    entry_t                                  wr_entry;
    logic                                    empty, full;
    logic                                    can_write, do_write, do_read, discard;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Round-robin search starting at prio_q over occupied holding registers.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_CHANNELS; off++) begin
            cand = {1'b0, prio_q} + CW1'(off);
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!gnt_found && hold_valid_q[cand[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CW-1:0];
            end
        end
    end

    // Write/read qualification; in overwrite mode a write into a full FIFO
    // without a concurrent pop drops the head instead.
    always_comb begin
        do_read   = read_enable && !empty;
        can_write = !full || do_read || (OVERWRITE_MODE != 0);
        do_write  = gnt_found && can_write;
        discard   = do_write && full && !do_read;
        wr_entry.ch   = gnt_idx;
        wr_entry.data = hold_data_q[gnt_idx];
    end

    // Next state for holding registers, pointers, count, arbiter and flags.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        prio_d       = prio_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;

        // A channel is never both granted and capturing: capture needs an empty register.
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (do_write && (gnt_idx == CW'(i))) begin
                hold_valid_d[i] = 1'b0;
            end
            if (sensor_valid[i] && !hold_valid_q[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = sensor_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            prio_d   = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CW'(1);
        end
        if (do_read || discard) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_write && !do_read && !discard) begin
            count_d = count_q + CNTW'(1);
        end else if (!do_write && do_read) begin
            count_d = count_q - CNTW'(1);
        end

        // Setting wins over a simultaneous clear.
        if (discard) begin
            ovf_d = 1'b1;
        end else if (clear_flags) begin
            ovf_d = 1'b0;
        end
        if (read_enable && empty) begin
            unf_d = 1'b1;
        end else if (clear_flags) begin
            unf_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            prio_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            prio_q       <= prio_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    // Storage array; contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Head is forced to zero when empty so reset and underflow leave a clean output.
    assign fifo_output    = empty ? '0 : head.data;
    assign fifo_channel   = empty ? '0 : head.ch;
    assign sensor_ready   = ~hold_valid_q;
    assign fifo_empty     = empty;
    assign fifo_full      = full;
    assign almost_full    = (count_q >= AF_LVL);
    assign almost_empty   = (count_q <= AE_LVL);
    assign fifo_count     = count_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

endmodule

// File: tb/tb_multichannel_sensor_fifo.sv
`timescale 1ns/1ps
// Testbench for multichannel_sensor_fifo: backpressure instance (dut0) and
// overwrite instance (dut1), directed vector table plus multi-cycle sequences.
module tb_multichannel_sensor_fifo;

    logic clk;
    logic reset;

    logic [3:0]  v0, rdy0, v1, rdy1;
    logic [31:0] d0, d1;
    logic        rd0, clr0, rd1, clr1;
    logic [7:0]  out0, out1;
    logic [1:0]  chn0, chn1;
    logic        emp0, full0, af0, ae0, ovf0, unf0;
    logic        emp1, full1, af1, ae1, ovf1, unf1;
    logic [5:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    multichannel_sensor_fifo #(.OVERWRITE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .sensor_valid(v0), .sensor_data(d0),
        .sensor_ready(rdy0), .read_enable(rd0), .fifo_output(out0),
        .fifo_channel(chn0), .fifo_empty(emp0), .fifo_full(full0),
        .almost_full(af0), .almost_empty(ae0), .fifo_count(cnt0),
        .overflow_flag(ovf0), .underflow_flag(unf0), .clear_flags(clr0)
    );

    multichannel_sensor_fifo #(.OVERWRITE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .sensor_valid(v1), .sensor_data(d1),
        .sensor_ready(rdy1), .read_enable(rd1), .fifo_output(out1),
        .fifo_channel(chn1), .fifo_empty(emp1), .fifo_full(full1),
        .almost_full(af1), .almost_empty(ae1), .fifo_count(cnt1),
        .overflow_flag(ovf1), .underflow_flag(unf1), .clear_flags(clr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        rd;
        logic        clr;
        int          cnt;
        logic [7:0]  out;
        logic [1:0]  ch;
        logic [3:0]  rdy;
        logic        unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d,
                                input logic rd, input logic clr, input int cnt,
                                input logic [7:0] out, input logic [1:0] ch,
                                input logic [3:0] rdy, input logic unf);
        vec_t r;
        r.v = v; r.d = d; r.rd = rd; r.clr = clr; r.cnt = cnt;
        r.out = out; r.ch = ch; r.rdy = rdy; r.unf = unf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic status0(input string tag, input int exp_cnt);
        chk({tag, "_count"}, 32'(cnt0), exp_cnt);
        chk({tag, "_empty"}, 32'(emp0), 32'(exp_cnt == 0));
        chk({tag, "_full"},  32'(full0), 32'(exp_cnt == 32));
        chk({tag, "_afull"}, 32'(af0), 32'(exp_cnt >= 28));
        chk({tag, "_aempty"}, 32'(ae0), 32'(exp_cnt <= 4));
    endtask

    task automatic status1(input string tag, input int exp_cnt);
        chk({tag, "_count"}, 32'(cnt1), exp_cnt);
        chk({tag, "_empty"}, 32'(emp1), 32'(exp_cnt == 0));
        chk({tag, "_full"},  32'(full1), 32'(exp_cnt == 32));
        chk({tag, "_afull"}, 32'(af1), 32'(exp_cnt >= 28));
        chk({tag, "_aempty"}, 32'(ae1), 32'(exp_cnt <= 4));
    endtask

    // One sample on one channel: wait (bounded) for ready, strobe for one edge.
    task automatic send(input int which, input int ch, input logic [7:0] d);
        int n = 0;
        while (((which == 0) ? rdy0[ch] : rdy1[ch]) !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut%0d ch%0d never ready", which, ch);
        end
        if (which == 0) begin
            v0 = '0; v0[ch] = 1'b1; d0 = '0; d0[ch*8 +: 8] = d;
        end else begin
            v1 = '0; v1[ch] = 1'b1; d1 = '0; d1[ch*8 +: 8] = d;
        end
        step();
        v0 = '0;
        v1 = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        v0 = '0; d0 = '0; rd0 = 1'b0; clr0 = 1'b0;
        v1 = '0; d1 = '0; rd1 = 1'b0; clr1 = 1'b0;

        // Arbitration burst from reset priority, second burst, single sample,
        // underflow/clear precedence, read-on-empty with concurrent write.
        tbl.push_back(mk(4'hF, 32'h13121110, 1'b0, 1'b0, 0, 8'h00, 2'd0, 4'h0, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 1, 8'h10, 2'd0, 4'h1, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 2, 8'h10, 2'd0, 4'h3, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 3, 8'h10, 2'd0, 4'h7, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 4, 8'h10, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 3, 8'h11, 2'd1, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 2, 8'h12, 2'd2, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 1, 8'h13, 2'd3, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'hA, 32'h23002100, 1'b0, 1'b0, 0, 8'h00, 2'd0, 4'h5, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 1, 8'h21, 2'd1, 4'h7, 1'b0));
        tbl.push_back(mk(4'h2, 32'h00003100, 1'b0, 1'b0, 2, 8'h21, 2'd1, 4'hD, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 3, 8'h21, 2'd1, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 2, 8'h23, 2'd3, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 1, 8'h31, 2'd1, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h4, 32'h00A50000, 1'b0, 1'b0, 0, 8'h00, 2'd0, 4'hB, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b0, 1, 8'hA5, 2'd2, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 2'd0, 4'hF, 1'b1));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b1, 0, 8'h00, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b1, 0, 8'h00, 2'd0, 4'hF, 1'b1));
        tbl.push_back(mk(4'h0, 32'h0,        1'b0, 1'b1, 0, 8'h00, 2'd0, 4'hF, 1'b0));
        tbl.push_back(mk(4'h1, 32'h00000055, 1'b0, 1'b0, 0, 8'h00, 2'd0, 4'hE, 1'b0));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b0, 1, 8'h55, 2'd0, 4'hF, 1'b1));
        tbl.push_back(mk(4'h0, 32'h0,        1'b1, 1'b1, 0, 8'h00, 2'd0, 4'hF, 1'b0));

        // Reset values while reset is held low.
        #1;
        status0("rst0", 0);
        chk("rst0_ready", 32'(rdy0), 32'hF);
        chk("rst0_out", 32'(out0), 0);
        chk("rst0_ch", 32'(chn0), 0);
        chk("rst0_ovf", 32'(ovf0), 0);
        chk("rst0_unf", 32'(unf0), 0);
        status1("rst1", 0);
        chk("rst1_ready", 32'(rdy1), 32'hF);
        chk("rst1_out", 32'(out1), 0);
        chk("rst1_ch", 32'(chn1), 0);
        chk("rst1_unf", 32'(unf1), 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v0 = tbl[i].v; d0 = tbl[i].d; rd0 = tbl[i].rd; clr0 = tbl[i].clr;
            step();
            status0($sformatf("row%0d", i), tbl[i].cnt);
            chk($sformatf("row%0d_out", i), 32'(out0), 32'(tbl[i].out));
            chk($sformatf("row%0d_ch", i), 32'(chn0), 32'(tbl[i].ch));
            chk($sformatf("row%0d_ready", i), 32'(rdy0), 32'(tbl[i].rdy));
            chk($sformatf("row%0d_unf", i), 32'(unf0), 32'(tbl[i].unf));
            chk($sformatf("row%0d_ovf", i), 32'(ovf0), 0);
        end
        rd0 = 1'b0; clr0 = 1'b0; v0 = '0;

        // Backpressure fill: all channels streaming, no reads, 40 edges.
        v0 = 4'hF; d0 = 32'h43424140;
        for (int n = 1; n <= 40; n++) begin
            step();
            status0($sformatf("fill%0d", n), (n - 1 > 32) ? 32 : n - 1);
        end
        chk("fill_ready", 32'(rdy0), 0);
        chk("fill_ovf", 32'(ovf0), 0);

        // Full with read: one grant and one pop, count unchanged.
        v0 = '0; rd0 = 1'b1;
        step();
        rd0 = 1'b0;
        status0("full_rw", 32);
        chk("full_rw_grants", 32'($countones(rdy0)), 1);
        chk("full_rw_ovf", 32'(ovf0), 0);

        // Overwrite instance: 32 samples fill, 33rd drops the oldest.
        for (int i = 0; i < 32; i++) begin
            send(1, 0, 8'(i));
        end
        step();
        status1("ow_fill", 32);
        chk("ow_fill_ovf", 32'(ovf1), 0);
        chk("ow_fill_head", 32'(out1), 0);
        send(1, 0, 8'd32);
        step();
        status1("ow_drop", 32);
        chk("ow_drop_ovf", 32'(ovf1), 1);
        chk("ow_drop_head", 32'(out1), 1);
        chk("ow_drop_ch", 32'(chn1), 0);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        status1("ow_pop", 31);
        chk("ow_pop_head", 32'(out1), 2);
        chk("ow_pop_ovf", 32'(ovf1), 1);
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        chk("ow_clr_ovf", 32'(ovf1), 0);
        chk("ow_clr_unf", 32'(unf1), 0);
        send(1, 0, 8'd33);
        step();
        status1("ow_refill", 32);
        chk("ow_refill_head", 32'(out1), 2);
        // Write and read on the same full edge advance the head only once.
        send(1, 0, 8'd34);
        rd1 = 1'b1;
        step();
        rd1 = 1'b0;
        status1("ow_rw", 32);
        chk("ow_rw_head", 32'(out1), 3);

        // Reset pulse, build occupancy 17, then reset mid-operation.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(0, 0, 8'(i + 8'h60));
        end
        step();
        status0("pre_rst", 17);
        chk("pre_rst_head", 32'(out0), 32'h60);
        reset = 1'b0;
        #1;
        status0("mid_rst", 0);
        chk("mid_rst_ready", 32'(rdy0), 32'hF);
        chk("mid_rst_out", 32'(out0), 0);
        chk("mid_rst_ch", 32'(chn0), 0);
        chk("mid_rst_ovf", 32'(ovf0), 0);
        chk("mid_rst_unf", 32'(unf0), 0);
        chk("mid_rst_cnt1", 32'(cnt1), 0);
        #1;
        reset = 1'b1;
        v0 = 4'b0010; d0 = 32'h00007700;
        step();
        v0 = '0;
        chk("post_rst_ready", 32'(rdy0), 32'hD);
        status0("post_rst_cap", 0);
        step();
        status0("post_rst_wr", 1);
        chk("post_rst_out", 32'(out0), 32'h77);
        chk("post_rst_ch", 32'(chn0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
